// File: rtl/vga_timing_pkg.sv
// Shared types and default 640x480@60 constants for the VGA raster timing generator.
// Optional feature macro used by the top: VGA_TG_PIXEL_STROBE_EN.
package vga_timing_pkg;

  typedef enum logic [1:0] {
    PH_ACTIVE = 2'd0,
    PH_FPORCH = 2'd1,
    PH_SYNC   = 2'd2,
    PH_BPORCH = 2'd3
  } phase_e;

  localparam int CW_DEF       = 11;
  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  function automatic int axis_total(input int act, input int fp, input int syn, input int bp);
    return act + fp + syn + bp;
  endfunction

  localparam int H_TOTAL_DEF = axis_total(H_ACTIVE_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF);
  localparam int V_TOTAL_DEF = axis_total(V_ACTIVE_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF);

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: ACTIVE/FPORCH/SYNC/BPORCH phase FSM with a phase counter and
// a position counter. o_wrap flags the advancing edge on the last BPORCH count.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE = H_ACTIVE_DEF,
  parameter int FPORCH = H_FP_DEF,
  parameter int SYNC   = H_SYNC_DEF,
  parameter int BPORCH = H_BP_DEF,
  parameter int CW     = CW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_adv,
  output logic [CW-1:0] o_pos,
  output logic          o_active,
  output logic          o_sync,
  output logic          o_wrap
);

  // Every phase must last at least one count, and the position must fit in CW bits.
  generate
    if (ACTIVE < 1 || FPORCH < 1 || SYNC < 1 || BPORCH < 1) begin : g_bad_len
      $error("vga_axis_counter: every phase length must be >= 1");
    end
    if (axis_total(ACTIVE, FPORCH, SYNC, BPORCH) > (1 << CW) - 1) begin : g_bad_total
      $error("vga_axis_counter: axis total does not fit in CW bits");
    end
  endgenerate

  localparam logic [CW-1:0] LEN_ACT = CW'(ACTIVE - 1);
  localparam logic [CW-1:0] LEN_FP  = CW'(FPORCH - 1);
  localparam logic [CW-1:0] LEN_SY  = CW'(SYNC - 1);
  localparam logic [CW-1:0] LEN_BP  = CW'(BPORCH - 1);

  phase_e        r_phase, w_phase_nxt;
  logic [CW-1:0] r_cnt, r_pos, w_len_m1;
  logic          w_last;

  always_comb begin
    w_len_m1 = LEN_ACT;
    case (r_phase)
      PH_FPORCH: w_len_m1 = LEN_FP;
      PH_SYNC:   w_len_m1 = LEN_SY;
      PH_BPORCH: w_len_m1 = LEN_BP;
      default:   w_len_m1 = LEN_ACT;
    endcase
  end

  assign w_last = (r_cnt == w_len_m1);

  always_comb begin
    w_phase_nxt = r_phase;
    if (i_adv && w_last) begin
      case (r_phase)
        PH_ACTIVE: w_phase_nxt = PH_FPORCH;
        PH_FPORCH: w_phase_nxt = PH_SYNC;
        PH_SYNC:   w_phase_nxt = PH_BPORCH;
        default:   w_phase_nxt = PH_ACTIVE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_phase <= PH_ACTIVE;
      r_cnt   <= '0;
      r_pos   <= '0;
    end else if (i_adv) begin
      r_phase <= w_phase_nxt;
      r_cnt   <= w_last ? '0 : r_cnt + CW'(1);
      r_pos   <= o_wrap ? '0 : r_pos + CW'(1);
    end
  end

  always_comb begin
    o_pos    = r_pos;
    o_active = (r_phase == PH_ACTIVE);
    o_sync   = (r_phase == PH_SYNC);
    o_wrap   = i_adv && (r_phase == PH_BPORCH) && w_last;
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: registered hsync/vsync/de, x/y and line/frame strobes.
// Define VGA_TG_PIXEL_STROBE_EN to add pix_ce and advance only on strobed edges.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE   = H_ACTIVE_DEF,
  parameter int   H_FP       = H_FP_DEF,
  parameter int   H_SYNC     = H_SYNC_DEF,
  parameter int   H_BP       = H_BP_DEF,
  parameter int   V_ACTIVE   = V_ACTIVE_DEF,
  parameter int   V_FP       = V_FP_DEF,
  parameter int   V_SYNC     = V_SYNC_DEF,
  parameter int   V_BP       = V_BP_DEF,
  parameter logic H_SYNC_POL = 1'b0,
  parameter logic V_SYNC_POL = 1'b0,
  parameter int   CW         = CW_DEF
) (
`ifdef VGA_TG_PIXEL_STROBE_EN
  input  logic          pix_ce,
`endif
  input  logic          clk,
  input  logic          rst,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          line_start,
  output logic          frame_start
);

  logic          w_adv, w_h_wrap, w_v_adv;
  logic          w_h_act, w_h_sync, w_v_act, w_v_sync;
  logic [CW-1:0] w_h_pos, w_v_pos;

`ifdef VGA_TG_PIXEL_STROBE_EN
  assign w_adv = pix_ce;
`else
  assign w_adv = 1'b1;
`endif

  assign w_v_adv = w_adv & w_h_wrap;

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FPORCH(H_FP), .SYNC(H_SYNC), .BPORCH(H_BP), .CW(CW)
  ) u_h (
    .clk(clk), .rst(rst), .i_adv(w_adv),
    .o_pos(w_h_pos), .o_active(w_h_act), .o_sync(w_h_sync), .o_wrap(w_h_wrap)
  );

  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FPORCH(V_FP), .SYNC(V_SYNC), .BPORCH(V_BP), .CW(CW)
  ) u_v (
    .clk(clk), .rst(rst), .i_adv(w_v_adv),
    .o_pos(w_v_pos), .o_active(w_v_act), .o_sync(w_v_sync), .o_wrap()
  );

  logic          r_hsync, r_vsync, r_de, r_line_start, r_frame_start;
  logic [CW-1:0] r_x, r_y;

  // Outputs show the counter state of the previous advancing edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hsync       <= ~H_SYNC_POL;
      r_vsync       <= ~V_SYNC_POL;
      r_de          <= 1'b0;
      r_x           <= '0;
      r_y           <= '0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else if (w_adv) begin
      r_hsync       <= w_h_sync ? H_SYNC_POL : ~H_SYNC_POL;
      r_vsync       <= w_v_sync ? V_SYNC_POL : ~V_SYNC_POL;
      r_de          <= w_h_act & w_v_act;
      r_x           <= w_h_pos;
      r_y           <= w_v_pos;
      r_line_start  <= (w_h_pos == '0);
      r_frame_start <= (w_h_pos == '0) && (w_v_pos == '0);
    end
  end

  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign de          = r_de;
  assign x           = r_x;
  assign y           = r_y;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;

endmodule
